crc_frame_checker: RTL and testbench

//  Receive-side partner of the parallel CRC encoder. Consumes a frame of DWIDTH-bit words
//  (payload words followed by one trailing CRC word) and runs a CRC across all payload words.

---
 rtl/crc_frame_checker.sv | 144 ++++++++++++++
 tb/tb_crc_frame_checker.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_checker.sv
// Receive-side CRC checker: CRC over the payload words, compared with the trailing CRC word.
// Result one cycle after the last word (frame_done_o); data_ready_o is low only in that result cycle.
module crc_frame_checker #(
   parameter int                   CRC_WIDTH = 16,
   parameter int                   DWIDTH    = 32,
   parameter logic [CRC_WIDTH-1:0] POLY      = 16'h1021,
   parameter logic [CRC_WIDTH-1:0] INIT      = 16'hFFFF,
   parameter logic [CRC_WIDTH-1:0] XOROUT    = 16'h0000,
   parameter int                   MAX_WORDS = 64,
   localparam int                  CNT_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [DWIDTH-1:0]    data_in_i,
   input  logic                 data_valid_i,
   input  logic                 data_last_i,
   output logic                 data_ready_o,
   output logic                 frame_done_o,
   output logic                 crc_ok_o,
   output logic                 crc_err_o,
   output logic                 len_err_o,
   output logic [CRC_WIDTH-1:0] crc_calc_o,
   output logic [CNT_W-1:0]     payload_words_o
);

   typedef enum logic [1:0] {IDLE, ACC, DROP, CHECK} state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

   state_t               state_q;
   logic [CRC_WIDTH-1:0] crc_acc_q;
   logic [CRC_WIDTH-1:0] crc_d;
   logic [CRC_WIDTH-1:0] crc_fin;
   logic [CRC_WIDTH-1:0] rx_crc;
   logic [CNT_W-1:0]     cnt_q;
   logic                 frame_done_q;
   logic                 crc_ok_q;
   logic                 crc_err_q;
   logic                 len_err_q;
   logic [CRC_WIDTH-1:0] crc_calc_q;
   logic [CNT_W-1:0]     words_q;
   logic                 accept;

   // MSB-first, non-reflected; the whole word is folded in within one cycle.
   function automatic logic [CRC_WIDTH-1:0] crc_update(input logic [CRC_WIDTH-1:0] crc,
                                                        input logic [DWIDTH-1:0]    d);
      logic [CRC_WIDTH-1:0] c;
      logic                 fb;
      c = crc;
      for (int b = DWIDTH - 1; b >= 0; b--) begin
         fb = c[CRC_WIDTH-1] ^ d[b];
         c  = (c << 1) ^ (fb ? POLY : '0);
      end
      return c;
   endfunction

   always_comb begin
      crc_d = crc_update(crc_acc_q, data_in_i);
   end

   assign crc_fin      = crc_acc_q ^ XOROUT;
   assign rx_crc       = data_in_i[CRC_WIDTH-1:0];
   assign data_ready_o = (state_q != CHECK);
   assign accept       = data_valid_i && data_ready_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         crc_acc_q    <= INIT;
         cnt_q        <= '0;
         frame_done_q <= 1'b0;
         crc_ok_q     <= 1'b0;
         crc_err_q    <= 1'b0;
         len_err_q    <= 1'b0;
         crc_calc_q   <= '0;
         words_q      <= '0;
      end else begin
         frame_done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  if (data_last_i) begin
                     crc_calc_q   <= crc_fin;
                     words_q      <= '0;
                     len_err_q    <= 1'b1;
                     crc_ok_q     <= 1'b0;
                     crc_err_q    <= 1'b0;
                     frame_done_q <= 1'b1;
                     state_q      <= CHECK;
                  end else begin
                     crc_acc_q <= crc_d;
                     cnt_q     <= CNT_W'(1);
                     state_q   <= ACC;
                  end
               end
            end
            ACC: begin
               if (accept) begin
                  if (data_last_i) begin
                     crc_calc_q   <= crc_fin;
                     words_q      <= cnt_q;
                     len_err_q    <= 1'b0;
                     crc_ok_q     <= (crc_fin == rx_crc);
                     crc_err_q    <= (crc_fin != rx_crc);
                     frame_done_q <= 1'b1;
                     state_q      <= CHECK;
                  end else if (cnt_q < MAX_CNT) begin
                     crc_acc_q <= crc_d;
                     cnt_q     <= cnt_q + CNT_W'(1);
                  end else begin
                     state_q <= DROP;
                  end
               end
            end
            // Oversized frame: swallow the rest, keep the CRC/count of the first MAX_WORDS.
            DROP: begin
               if (accept && data_last_i) begin
                  crc_calc_q   <= crc_fin;
                  words_q      <= cnt_q;
                  len_err_q    <= 1'b1;
                  crc_ok_q     <= 1'b0;
                  crc_err_q    <= 1'b0;
                  frame_done_q <= 1'b1;
                  state_q      <= CHECK;
               end
            end
            CHECK: begin
               crc_acc_q <= INIT;
               cnt_q     <= '0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign frame_done_o    = frame_done_q;
   assign crc_ok_o        = crc_ok_q;
   assign crc_err_o       = crc_err_q;
   assign len_err_o       = len_err_q;
   assign crc_calc_o      = crc_calc_q;
   assign payload_words_o = words_q;

endmodule

// File: tb/tb_crc_frame_checker.sv
// Bench: two checkers with different seeds/XOROUT/size limits share one input stream;
// results are predicted by polynomial long division over the frame's bit string.
module tb_crc_frame_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] din = '0;
   logic        dv  = 1'b0;
   logic        dl  = 1'b0;

   logic        rdy_a, done_a, ok_a, err_a, len_a;
   logic [15:0] calc_a;
   logic [2:0]  wd_a;
   logic        rdy_b, done_b, ok_b, err_b, len_b;
   logic [15:0] calc_b;
   logic [2:0]  wd_b;

   localparam logic [15:0] A_INIT = 16'h0000, A_XO = 16'h0000;
   localparam int          A_MAX  = 4;
   localparam logic [15:0] B_INIT = 16'hFFFF, B_XO = 16'h5A5A;
   localparam int          B_MAX  = 5;

   crc_frame_checker #(.INIT(A_INIT), .XOROUT(A_XO), .MAX_WORDS(A_MAX)) dut_a (
      .clk_i(clk), .rst_i(rst), .data_in_i(din), .data_valid_i(dv), .data_last_i(dl),
      .data_ready_o(rdy_a), .frame_done_o(done_a), .crc_ok_o(ok_a), .crc_err_o(err_a),
      .len_err_o(len_a), .crc_calc_o(calc_a), .payload_words_o(wd_a));

   crc_frame_checker #(.INIT(B_INIT), .XOROUT(B_XO), .MAX_WORDS(B_MAX)) dut_b (
      .clk_i(clk), .rst_i(rst), .data_in_i(din), .data_valid_i(dv), .data_last_i(dl),
      .data_ready_o(rdy_b), .frame_done_o(done_b), .crc_ok_o(ok_b), .crc_err_o(err_b),
      .len_err_o(len_b), .crc_calc_o(calc_b), .payload_words_o(wd_b));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Pending word stream: data, last flag, idle cycles before the word.
   logic [31:0] s_dat[$];
   bit          s_last[$];
   int          s_gap[$];
   logic [31:0] pay[8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Remainder of (message * x^16) mod G, with the seed folded into the first 16 message bits.
   function automatic logic [15:0] ref_crc(input logic [15:0] init, input int m);
      bit          bits[0:271];
      logic [16:0] g;
      logic [15:0] r;
      int          len;
      g   = 17'h11021;
      len = m * 32;
      for (int i = 0; i < m; i++)
         for (int b = 0; b < 32; b++) bits[i*32 + 31 - b] = pay[i][b];
      for (int i = 0; i < 16; i++) bits[i] ^= init[15-i];
      for (int i = 0; i < 16; i++) bits[len+i] = 1'b0;
      for (int i = 0; i < len; i++)
         if (bits[i])
            for (int j = 0; j <= 16; j++) bits[i+j] ^= g[16-j];
      for (int k = 0; k < 16; k++) r[15-k] = bits[len+k];
      return r;
   endfunction

   function automatic logic [15:0] exp_crc(input logic [15:0] init, input logic [15:0] xo,
                                           input int max, input int n);
      int m;
      m = (n > max) ? max : n;
      return ((m == 0) ? init : ref_crc(init, m)) ^ xo;
   endfunction

   task automatic push(input logic [31:0] d, input bit l, input int gap);
      s_dat.push_back(d);
      s_last.push_back(l);
      s_gap.push_back(gap);
   endtask

   // tgt: 0 = CRC built for checker A, 1 = for checker B, 2 = random CRC word.
   task automatic build_frame(input int n, input int tgt, input bit corrupt, input int gap);
      logic [31:0] w;
      logic [15:0] c;
      for (int i = 0; i < n; i++) begin
         pay[i] = $urandom;
         push(pay[i], 1'b0, (i == 0) ? gap : 0);
      end
      w = $urandom;
      if (tgt == 0)      c = exp_crc(A_INIT, A_XO, A_MAX, n);
      else if (tgt == 1) c = exp_crc(B_INIT, B_XO, B_MAX, n);
      else               c = w[15:0];
      if (corrupt) c ^= 16'(1 << $urandom_range(15, 0));
      w[15:0] = c;
      push(w, 1'b1, (n == 0) ? gap : 0);
   endtask

   task automatic put_word(input logic [31:0] d, input bit l);
      din = d;
      dl  = l;
      dv  = 1'b1;
      @(negedge clk);
      chk("ready_a", 32'(rdy_a), 32'd1);
      chk("ready_b", 32'(rdy_b), 32'd1);
      chk("no_done_a", 32'(done_a), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic expect_res(input string who, input logic ok, input logic err, input logic len,
                             input logic [15:0] calc, input logic [2:0] wd,
                             input logic [15:0] init, input logic [15:0] xo, input int max,
                             input int n, input logic [31:0] w);
      logic [15:0] ec;
      logic        el, eok;
      ec  = exp_crc(init, xo, max, n);
      el  = (n == 0) || (n > max);
      eok = !el && (ec == w[15:0]);
      chk({who, ".crcCalc"}, 32'(calc), 32'(ec));
      chk({who, ".lenErr"}, 32'(len), 32'(el));
      chk({who, ".crcOk"}, 32'(ok), 32'(eok));
      chk({who, ".crcErr"}, 32'(err), 32'(!el && !eok));
      chk({who, ".words"}, 32'(wd), (n > max) ? max : n);
   endtask

   // Called just after the edge that accepted the CRC word.
   task automatic check_frame(input int n, input logic [31:0] w);
      logic [15:0] held;
      @(negedge clk);
      chk("done_a", 32'(done_a), 32'd1);
      chk("done_b", 32'(done_b), 32'd1);
      chk("check_ready_a", 32'(rdy_a), 32'd0);
      chk("check_ready_b", 32'(rdy_b), 32'd0);
      expect_res("A", ok_a, err_a, len_a, calc_a, wd_a, A_INIT, A_XO, A_MAX, n, w);
      expect_res("B", ok_b, err_b, len_b, calc_b, wd_b, B_INIT, B_XO, B_MAX, n, w);
      held = calc_b;
      @(posedge clk);
      #1;
      chk("done_pulse_a", 32'(done_a), 32'd0);
      chk("ready_back_a", 32'(rdy_a), 32'd1);
      chk("hold_calc_b", 32'(calc_b), 32'(held));
   endtask

   task automatic run_stream();
      logic [31:0] d;
      bit          l;
      int          g, pn;
      pn = 0;
      while (s_dat.size() > 0) begin
         d = s_dat.pop_front();
         l = s_last.pop_front();
         g = s_gap.pop_front();
         repeat (g) begin
            dv  = 1'b0;
            din = $urandom;
            dl  = 1'($urandom);
            @(posedge clk);
            #1;
         end
         put_word(d, l);
         if (!l) begin
            if (pn < 8) pay[pn] = d;
            pn++;
         end else begin
            // Next frame with no gap keeps dataValid high straight through the result cycle.
            if (s_dat.size() > 0 && s_gap[0] == 0) begin
               din = s_dat[0];
               dl  = s_last[0];
               dv  = 1'b1;
            end else begin
               dv  = 1'b0;
               din = $urandom;
               dl  = 1'($urandom);
            end
            check_frame(pn, d);
            pn = 0;
         end
      end
      dv = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      chk("rst_ready_a", 32'(rdy_a), 32'd1);
      chk("rst_done_a", 32'(done_a), 32'd0);
      chk("rst_flags_a", {29'd0, ok_a, err_a, len_a}, 32'd0);
      chk("rst_calc_a", 32'(calc_a), 32'd0);
      chk("rst_words_b", 32'(wd_b), 32'd0);
      chk("rst_flags_b", {29'd0, ok_b, err_b, len_b}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Known answer with zero seed.
      push(32'h0000_0001, 1'b0, 1);
      push(32'h0000_1021, 1'b1, 0);
      run_stream();
      chk("kat_calc", 32'(calc_a), 32'h1021);
      chk("kat_ok", 32'(ok_a), 32'd1);
      chk("kat_words", 32'(wd_a), 32'd1);

      push(32'h0000_0001, 1'b0, 1);
      push(32'hABCD_1020, 1'b1, 0);
      run_stream();
      chk("kat_bad_err", 32'(err_a), 32'd1);
      chk("kat_bad_calc", 32'(calc_a), 32'h1021);

      // Zero payload, oversize for both limits, and size that only fits B.
      build_frame(0, 0, 1'b0, 1);
      build_frame(6, 1, 1'b0, 0);
      build_frame(5, 1, 1'b0, 2);
      build_frame(4, 0, 1'b0, 0);
      run_stream();

      // Back-to-back good frames, then random mix.
      build_frame(2, 0, 1'b0, 1);
      build_frame(3, 0, 1'b0, 0);
      build_frame(2, 1, 1'b0, 0);
      build_frame(1, 1, 1'b1, 0);
      for (int k = 0; k < 14; k++)
         build_frame($urandom_range(6, 0), $urandom_range(2, 0), ($urandom_range(3, 0) == 0),
                     ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(3, 1));
      run_stream();

      // Reset in the middle of a frame: partial frame must vanish without a result.
      for (int i = 0; i < 3; i++) put_word($urandom, 1'b0);
      dv = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_ready", 32'(rdy_a), 32'd1);
      chk("mid_rst_flags_a", {29'd0, ok_a, err_a, len_a}, 32'd0);
      chk("mid_rst_words_b", 32'(wd_b), 32'd0);
      #4 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_rst_no_done", 32'(done_a | done_b), 32'd0);
      end
      @(posedge clk);
      #1;
      build_frame(1, 0, 1'b0, 0);
      run_stream();
      chk("post_rst_ok", 32'(ok_a), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
